// File: rtl/rf_wb_scheduler_if.sv
// Writeback request, issue/decode and register-file write-port bundle for rf_wb_scheduler.
interface rf_wb_scheduler_if #(
  parameter int XLEN   = 32,
  parameter int NREG_W = 5
);
  logic              alu_req;
  logic [NREG_W-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ack;

  logic              ld_req;
  logic [NREG_W-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              ld_ack;

  logic              iss_valid;
  logic [NREG_W-1:0] iss_rd;
  logic [NREG_W-1:0] rs1;
  logic [NREG_W-1:0] rs2;
  logic              stall;

  logic              rf_we;
  logic [NREG_W-1:0] rf_a3;
  logic [XLEN-1:0]   rf_wd;

  // Pipeline side: execute/memory/decode stages and REG_FILE.
  modport master (
    output alu_req, alu_rd, alu_data,
    input  alu_ack,
    output ld_req, ld_rd, ld_data,
    input  ld_ack,
    output iss_valid, iss_rd, rs1, rs2,
    input  stall,
    input  rf_we, rf_a3, rf_wd
  );

  // Scheduler side.
  modport slave (
    input  alu_req, alu_rd, alu_data,
    output alu_ack,
    input  ld_req, ld_rd, ld_data,
    output ld_ack,
    input  iss_valid, iss_rd, rs1, rs2,
    output stall,
    output rf_we, rf_a3, rf_wd
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port arbiter (ALU vs load) with per-register busy scoreboard.
module rf_wb_scheduler #(
  parameter int XLEN       = 32,
  parameter int NREG_W     = 5,
  parameter int STARVE_LIM = 4
) (
  input  logic             clk,
  input  logic             res,
  rf_wb_scheduler_if.slave bus
);
  localparam int NREG  = 1 << NREG_W;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [NREG_W-1:0] rf_a3_q, rf_a3_d;
  logic [XLEN-1:0]   rf_wd_q, rf_wd_d;

  logic alu_win, ld_win, stall;

  // Arbitration: load has priority unless the ALU has been starved long enough.
  always_comb begin
    alu_win = 1'b0;
    ld_win  = 1'b0;
    if (!res) begin
      if (bus.alu_req && (!bus.ld_req || starve_q >= LIM)) alu_win = 1'b1;
      else if (bus.ld_req)                                 ld_win  = 1'b1;
    end
  end

  // Decode stall on any pending write to a non-zero source register.
  always_comb begin
    stall = 1'b0;
    if (!res)
      stall = (bus.rs1 != '0 && busy_q[bus.rs1]) || (bus.rs2 != '0 && busy_q[bus.rs2]);
  end

  // Next-state: starve counter, write stage, scoreboard.
  always_comb begin
    starve_d = '0;
    if (bus.alu_req && !alu_win)
      starve_d = (starve_q >= LIM) ? LIM : starve_q + 1'b1;

    rf_we_d = 1'b0;
    rf_a3_d = rf_a3_q;
    rf_wd_d = rf_wd_q;
    if (alu_win) begin
      rf_a3_d = bus.alu_rd;
      rf_wd_d = bus.alu_data;
      rf_we_d = (bus.alu_rd != '0);
    end else if (ld_win) begin
      rf_a3_d = bus.ld_rd;
      rf_wd_d = bus.ld_data;
      rf_we_d = (bus.ld_rd != '0);
    end

    // Clear first, then set, so a new producer issued on the commit edge stays outstanding.
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_a3_q] = 1'b0;
    if (bus.iss_valid && !stall && bus.iss_rd != '0) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      busy_q   <= '0;
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  assign bus.alu_ack = alu_win;
  assign bus.ld_ack  = ld_win;
  assign bus.stall   = stall;
  assign bus.rf_we   = rf_we_q;
  assign bus.rf_a3   = rf_a3_q;
  assign bus.rf_wd   = rf_wd_q;
endmodule
